// File: rtl/keymap_pkg.sv
// Shared definitions for the WASDE key-mapping learner: slot count, index
// width, logical slot names, FSM state type and the power-up identity table.
package keymap_pkg;

   localparam int unsigned N_KEYS    = 5;
   localparam int unsigned KEY_IDX_W = 3;

   // Logical slot indices, in learn order
   localparam logic [KEY_IDX_W-1:0] KEY_W = 3'd0;
   localparam logic [KEY_IDX_W-1:0] KEY_A = 3'd1;
   localparam logic [KEY_IDX_W-1:0] KEY_S = 3'd2;
   localparam logic [KEY_IDX_W-1:0] KEY_D = 3'd3;
   localparam logic [KEY_IDX_W-1:0] KEY_E = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_REL,
      ST_LEARN,
      ST_COMMIT
   } state_t;

   // Slot i bound to physical button i
   function automatic logic [N_KEYS*KEY_IDX_W-1:0] identity_map();
      identity_map = '0;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
         identity_map[i*KEY_IDX_W +: KEY_IDX_W] = KEY_IDX_W'(i);
      end
   endfunction

   localparam logic [N_KEYS*KEY_IDX_W-1:0] IDENTITY_MAP = identity_map();

endpackage

// File: rtl/key_debounce.sv
// Per-button input conditioning: 2-flop synchroniser, stability counter and
// rising-edge detect on the accepted (stable) level.
module key_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 200000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key,
   output logic stable,
   output logic press
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] cnt;

   // Synchronise, count cycles the synced level disagrees with the stable level, flip when long enough
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         cnt    <= '0;
         stable <= 1'b0;
         press  <= 1'b0;
      end else begin
         sync1 <= key;
         sync2 <= sync1;
         press <= 1'b0;
         if (sync2 != stable) begin
            if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
               stable <= sync2;
               cnt    <= '0;
               press  <= sync2;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/keymap_learner.sv
// Writer side of the WASDE key-mapping table. A learn session binds one
// physical button per logical slot and commits the whole table at once.
// Optional session timeout enabled by defining KEYMAP_TIMEOUT_EN.
module keymap_learner
   import keymap_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 200000
`ifdef KEYMAP_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYCLES  = 500000000
`endif
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [N_KEYS-1:0]             key_i,
   input  logic                          start_i,
   input  logic                          abort_i,
   output logic [N_KEYS*KEY_IDX_W-1:0]   map_o,
   output logic [KEY_IDX_W-1:0]          slot_o,
   output logic                          busy_o,
   output logic                          done_o,
   output logic                          err_o,
   output logic                          timeout_o
);

   state_t                              state;
   logic [N_KEYS-1:0][KEY_IDX_W-1:0]    shadow;
   logic [N_KEYS-1:0]                   stable;
   logic [N_KEYS-1:0]                   press;
   logic [KEY_IDX_W-1:0]                n_press;
   logic [KEY_IDX_W-1:0]                press_idx;
   logic                                dup;
   logic                                accept;
   logic                                active;
   logic                                tmo_hit;

   for (genvar g = 0; g < N_KEYS; g++) begin : g_deb
      key_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
         .clk    (clk),
         .rst_n  (rst_n),
         .key    (key_i[g]),
         .stable (stable[g]),
         .press  (press[g])
      );
   end

   // Count press events, find the pressed key and check it against slots already learned
   always_comb begin
      n_press   = '0;
      press_idx = '0;
      dup       = 1'b0;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
         if (press[i]) begin
            n_press   = n_press + 1'b1;
            press_idx = KEY_IDX_W'(i);
         end
      end
      for (int unsigned i = 0; i < N_KEYS; i++) begin
         if ((KEY_IDX_W'(i) < slot_o) && (shadow[i] == press_idx)) begin
            dup = 1'b1;
         end
      end
      accept = (state == ST_LEARN) && (n_press == KEY_IDX_W'(1)) && !dup;
      active = (state == ST_WAIT_REL) || (state == ST_LEARN);
   end

`ifdef KEYMAP_TIMEOUT_EN
   logic [31:0] tcnt;

   // Idle-cycle counter: runs only inside a session, restarts on every accepted key
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tcnt <= '0;
      end else if (active && !accept) begin
         tcnt <= tcnt + 1'b1;
      end else begin
         tcnt <= '0;
      end
   end

   assign tmo_hit = active && !accept && (tcnt == 32'(TIMEOUT_CYCLES - 1));
`else
   assign tmo_hit   = 1'b0;
   assign timeout_o = 1'b0;
`endif

   // Session FSM: shadow table fill, duplicate rejection and atomic commit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         shadow    <= IDENTITY_MAP;
         map_o     <= IDENTITY_MAP;
         slot_o    <= '0;
         busy_o    <= 1'b0;
         done_o    <= 1'b0;
         err_o     <= 1'b0;
`ifdef KEYMAP_TIMEOUT_EN
         timeout_o <= 1'b0;
`endif
      end else begin
         done_o    <= 1'b0;
         err_o     <= 1'b0;
`ifdef KEYMAP_TIMEOUT_EN
         timeout_o <= 1'b0;
`endif
         if ((state != ST_IDLE) && abort_i) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
            slot_o <= '0;
         end else if (tmo_hit) begin
            state     <= ST_IDLE;
            busy_o    <= 1'b0;
            slot_o    <= '0;
`ifdef KEYMAP_TIMEOUT_EN
            timeout_o <= 1'b1;
`endif
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start_i && !abort_i) begin
                     shadow <= map_o;
                     slot_o <= '0;
                     busy_o <= 1'b1;
                     state  <= ST_WAIT_REL;
                  end
               end
               ST_WAIT_REL: begin
                  if (stable == '0) begin
                     state <= ST_LEARN;
                  end
               end
               ST_LEARN: begin
                  if (n_press > KEY_IDX_W'(1)) begin
                     err_o <= 1'b1;
                  end else if (n_press == KEY_IDX_W'(1)) begin
                     if (dup) begin
                        err_o <= 1'b1;
                     end else begin
                        shadow[slot_o] <= press_idx;
                        if (slot_o == KEY_E) begin
                           state <= ST_COMMIT;
                        end else begin
                           slot_o <= slot_o + 1'b1;
                           state  <= ST_WAIT_REL;
                        end
                     end
                  end
               end
               ST_COMMIT: begin
                  map_o  <= shadow;
                  done_o <= 1'b1;
                  busy_o <= 1'b0;
                  slot_o <= '0;
                  state  <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_keymap_learner.sv
// Self-checking bench for keymap_learner: behavioural model compared every
// cycle, directed scenarios with literal expectations, then random stimulus.
module tb_keymap_learner;

   localparam int DEB = 4;
   localparam int TO  = 64;
   localparam int NK  = 5;

   localparam int P_IDLE  = 0;
   localparam int P_WAIT  = 1;
   localparam int P_LEARN = 2;
   localparam int P_COMMIT = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  key_i = '0;
   logic        start_i = 1'b0;
   logic        abort_i = 1'b0;
   logic [14:0] map_o;
   logic [2:0]  slot_o;
   logic        busy_o, done_o, err_o, timeout_o;

   keymap_learner #(
      .DEBOUNCE_CYCLES(DEB)
`ifdef KEYMAP_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES(TO)
`endif
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_i     (key_i),
      .start_i   (start_i),
      .abort_i   (abort_i),
      .map_o     (map_o),
      .slot_o    (slot_o),
      .busy_o    (busy_o),
      .done_o    (done_o),
      .err_o     (err_o),
      .timeout_o (timeout_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   int err_cnt  = 0;
   int to_cnt   = 0;

   // ---------------- behavioural model ----------------
   int m_sync1[NK], m_sync2[NK], m_stable[NK], m_run[NK], m_press[NK];
   int m_map[NK], m_shadow[NK];
   int m_phase, m_slot, m_busy, m_done, m_err, m_tmo, m_tcnt;

   task automatic model_reset();
      for (int k = 0; k < NK; k++) begin
         m_sync1[k] = 0; m_sync2[k] = 0; m_stable[k] = 0; m_run[k] = 0; m_press[k] = 0;
         m_map[k] = k; m_shadow[k] = k;
      end
      m_phase = P_IDLE; m_slot = 0; m_busy = 0; m_done = 0; m_err = 0; m_tmo = 0; m_tcnt = 0;
   endtask

   task automatic model_step();
      int np, pk;
      bit dup, acc, all_rel, active, thit;
      np = 0; pk = 0; all_rel = 1; dup = 0; thit = 0;
      for (int k = 0; k < NK; k++) begin
         if (m_press[k] != 0) begin np++; pk = k; end
         if (m_stable[k] != 0) all_rel = 0;
      end
      for (int i = 0; i < m_slot; i++) if (m_shadow[i] == pk) dup = 1;
      acc = (m_phase == P_LEARN) && (np == 1) && !dup;
      active = (m_phase == P_WAIT) || (m_phase == P_LEARN);
      m_done = 0; m_err = 0; m_tmo = 0;
`ifdef KEYMAP_TIMEOUT_EN
      if (active && !acc && m_tcnt == TO - 1) thit = 1;
      if (active) m_tcnt = acc ? 0 : m_tcnt + 1;
`endif
      if (m_phase != P_IDLE && abort_i) begin
         m_phase = P_IDLE; m_busy = 0; m_slot = 0;
      end else if (thit) begin
         m_phase = P_IDLE; m_busy = 0; m_slot = 0; m_tmo = 1;
      end else begin
         case (m_phase)
            P_IDLE: if (start_i && !abort_i) begin
               for (int i = 0; i < NK; i++) m_shadow[i] = m_map[i];
               m_slot = 0; m_busy = 1; m_phase = P_WAIT; m_tcnt = 0;
            end
            P_WAIT: if (all_rel) m_phase = P_LEARN;
            P_LEARN: begin
               if (np >= 2) m_err = 1;
               else if (np == 1) begin
                  if (dup) m_err = 1;
                  else begin
                     m_shadow[m_slot] = pk;
                     if (m_slot == NK - 1) m_phase = P_COMMIT;
                     else begin m_slot++; m_phase = P_WAIT; end
                  end
               end
            end
            default: begin
               for (int i = 0; i < NK; i++) m_map[i] = m_shadow[i];
               m_done = 1; m_busy = 0; m_slot = 0; m_phase = P_IDLE;
            end
         endcase
      end
      // debouncer: stable level flips on the DEB-th consecutive cycle the synced level differs
      for (int k = 0; k < NK; k++) begin
         m_press[k] = 0;
         if (m_sync2[k] != m_stable[k]) begin
            m_run[k]++;
            if (m_run[k] == DEB) begin
               m_stable[k] = m_sync2[k];
               m_run[k] = 0;
               m_press[k] = m_stable[k];
            end
         end else m_run[k] = 0;
         m_sync2[k] = m_sync1[k];
         m_sync1[k] = int'(key_i[k]);
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk);
         if (!rst_n) model_reset();
         else model_step();
      end
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [14:0] model_map();
      logic [14:0] v;
      v = '0;
      for (int i = 0; i < NK; i++) v[i*3 +: 3] = 3'(m_map[i]);
      return v;
   endfunction

   // compare DUT against model on every cycle out of reset
   always @(negedge clk) begin
      if (rst_n) begin
         check("map_o", 32'(map_o), 32'(model_map()));
         check("slot_o", 32'(slot_o), 32'(m_slot));
         check("busy_o", 32'(busy_o), 32'(m_busy));
         check("done_o", 32'(done_o), 32'(m_done));
         check("err_o", 32'(err_o), 32'(m_err));
         check("timeout_o", 32'(timeout_o), 32'(m_tmo));
         if (done_o === 1'b1) done_cnt++;
         if (err_o === 1'b1) err_cnt++;
         if (timeout_o === 1'b1) to_cnt++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic pulse_start();
      start_i = 1'b1; tick(1); start_i = 1'b0;
   endtask

   task automatic pulse_abort();
      abort_i = 1'b1; tick(1); abort_i = 1'b0;
   endtask

   task automatic press(input logic [4:0] mask, input int hold, input int rel);
      key_i = mask; tick(hold); key_i = '0; tick(rel);
   endtask

   int d0, e0;
   logic [14:0] rev_map;

   initial begin
      rev_map = 15'b000_001_010_011_100;
      tick(3);
      rst_n = 1'b1;
      tick(2);
      #1;
      // 1. reset state
      check("reset_map", 32'(map_o), 32'(15'b100_011_010_001_000));
      check("reset_busy", 32'(busy_o), 32'd0);
      check("reset_slot", 32'(slot_o), 32'd0);

      // 2. full session, keys 4..0
      pulse_start();
      tick(2);
      for (int k = 4; k >= 0; k--) press(5'(1 << k), 10, 10);
      check("learn_done_count", 32'(done_cnt), 32'd1);
      check("learn_map", 32'(map_o), 32'(rev_map));
      check("learn_busy", 32'(busy_o), 32'd0);

      // 3. bouncing key 2 produces no press
      pulse_start();
      tick(3);
      e0 = err_cnt;
      for (int i = 0; i < 20; i++) begin
         key_i[2] = ((i / 2) % 2 == 0);
         tick(1);
      end
      key_i = '0;
      tick(10);
      check("bounce_slot", 32'(slot_o), 32'd0);
      check("bounce_err", 32'(err_cnt - e0), 32'd0);
      check("bounce_busy", 32'(busy_o), 32'd1);

      // 4. duplicate and simultaneous presses rejected
      press(5'b01000, 10, 10);
      check("slot_after_key3", 32'(slot_o), 32'd1);
      e0 = err_cnt;
      press(5'b01000, 10, 10);
      check("dup_err", 32'(err_cnt - e0), 32'd1);
      check("dup_slot", 32'(slot_o), 32'd1);
      press(5'b00011, 10, 10);
      check("multi_err", 32'(err_cnt - e0), 32'd2);
      check("multi_slot", 32'(slot_o), 32'd1);

      // 5. abort after three accepted keys
      press(5'b00001, 10, 10);
      press(5'b00010, 10, 10);
      check("pre_abort_slot", 32'(slot_o), 32'd3);
      d0 = done_cnt;
      pulse_abort();
      #1;
      check("abort_busy", 32'(busy_o), 32'd0);
      check("abort_map", 32'(map_o), 32'(rev_map));
      tick(5);
      check("abort_no_done", 32'(done_cnt - d0), 32'd0);

      // 6. idle session
      e0 = to_cnt;
      pulse_start();
      tick(80);
`ifdef KEYMAP_TIMEOUT_EN
      check("timeout_pulse", 32'(to_cnt - e0), 32'd1);
      check("timeout_busy", 32'(busy_o), 32'd0);
      check("timeout_map", 32'(map_o), 32'(rev_map));
`else
      check("no_timeout_busy", 32'(busy_o), 32'd1);
      check("no_timeout_pulse", 32'(to_cnt - e0), 32'd0);
      pulse_abort();
`endif
      tick(3);

      // random phase, model checked every cycle
      for (int it = 0; it < 220; it++) begin
         int r;
         logic [4:0] m;
         r = $urandom_range(0, 99);
         if (r < 10) pulse_start();
         else if (r < 13) pulse_abort();
         else if (r < 14) begin
            rst_n = 1'b0; tick(2); rst_n = 1'b1; tick(1);
         end else begin
            m = 5'(1 << $urandom_range(0, 4));
            if ($urandom_range(0, 99) < 15) m = m | 5'(1 << $urandom_range(0, 4));
            if ($urandom_range(0, 99) < 10) start_i = 1'b1;
            tick(1);
            start_i = 1'b0;
            press(m, $urandom_range(1, 14), $urandom_range(1, 14));
         end
      end
      tick(5);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
